// File: rtl/hub75_pkg.sv
// Shared types and sizing helpers for the HUB75 capture block.
//   rgb_t        - one pixel as shifted on a HUB75 data triple {r,g,b}
//   buf_state_e  - occupancy of the captured-row output buffer
//   row_width()  - packed row width for a given column count
//   addr_width() - row-address width for a given scan rate
package hub75_pkg;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam int RGB_W         = $bits(rgb_t);
  localparam int DEF_NUM_COLS  = 64;
  localparam int DEF_SCAN_RATE = 32;

  localparam int ROW_W  = DEF_NUM_COLS * RGB_W;
  localparam int ADDR_W = $clog2(DEF_SCAN_RATE);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  function automatic int row_width(input int cols);
    return cols * RGB_W;
  endfunction

  function automatic int addr_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/hub75_capture_if.sv
// Captured-row stream between hub75_capture (master) and its consumer (slave).
//   row_valid_out / row_ready_in - valid/ready handshake
//   row_addr_out                 - row address sampled at latch
//   row_top_out / row_bot_out    - packed rows, pixel i at [3i+2:3i]
//   pixel_count_out              - shift clocks seen before the latch
//   oe_cycles_out                - system-clock cycles OE was active for the row
interface hub75_capture_if
  import hub75_pkg::*;
#(
  parameter int NUM_COLS  = DEF_NUM_COLS,
  parameter int SCAN_RATE = DEF_SCAN_RATE,
  parameter int OE_CNT_W  = 16
) ();

  logic                              row_valid_out;
  logic                              row_ready_in;
  logic [$clog2(SCAN_RATE)-1:0]      row_addr_out;
  logic [NUM_COLS*RGB_W-1:0]         row_top_out;
  logic [NUM_COLS*RGB_W-1:0]         row_bot_out;
  logic [$clog2(NUM_COLS+1)-1:0]     pixel_count_out;
  logic [OE_CNT_W-1:0]               oe_cycles_out;

  modport master (
    output row_valid_out, row_addr_out, row_top_out, row_bot_out,
           pixel_count_out, oe_cycles_out,
    input  row_ready_in
  );

  modport slave (
    input  row_valid_out, row_addr_out, row_top_out, row_bot_out,
           pixel_count_out, oe_cycles_out,
    output row_ready_in
  );

endinterface

// File: rtl/hub75_edge_sync.sv
// Two-flop synchronizer with a delayed copy and a rising-edge pulse.
//   clk_in    - system clock
//   rst_in    - asynchronous active-low reset (clears all stages)
//   data_in   - asynchronous inputs
//   level_out - synchronized level (second stage)
//   rise_out  - one-cycle pulse when level_out goes 0 -> 1
// Every bus using this block sees the same depth, so control edges and
// data stay aligned after synchronization.
module hub75_edge_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_out
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] s3;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= data_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level_out = s2;
  assign rise_out  = s2 & ~s3;

endmodule

// File: rtl/hub75_capture.sv
// HUB75 receive-side capture: oversamples the panel pins on clk_in, rebuilds
// each shifted row and offers it on a valid/ready stream.
//   clk_in, rst_in          - system clock, asynchronous active-low reset
//   hub75_clk_in            - panel shift clock (rising edge shifts)
//   hub75_latch_in          - panel latch (rising edge commits a row)
//   hub75_oe_in             - output enable, active low
//   hub75_addr_in           - row address
//   hub75_rgb0_in/rgb1_in   - top/bottom half pixel bits {r,g,b}
//   row_if (master)         - captured row stream
//   len_err_out             - pulse: committed row had a pixel count != NUM_COLS
//   overrun_out             - sticky: a row was dropped while the buffer was full
//
// Output buffer FSM
//   state | meaning
//   EMPTY | no row held, row_valid_out low
//   FULL  | row held, outputs frozen until accepted
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int NUM_COLS  = DEF_NUM_COLS,
  parameter int SCAN_RATE = DEF_SCAN_RATE,
  parameter int OE_CNT_W  = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         hub75_clk_in,
  input  logic                         hub75_latch_in,
  input  logic                         hub75_oe_in,
  input  logic [$clog2(SCAN_RATE)-1:0] hub75_addr_in,
  input  logic [2:0]                   hub75_rgb0_in,
  input  logic [2:0]                   hub75_rgb1_in,
  hub75_capture_if.master              row_if,
  output logic                         len_err_out,
  output logic                         overrun_out
);

  localparam int AW = addr_width(SCAN_RATE);
  localparam int RW = row_width(NUM_COLS);
  localparam int CW = $clog2(NUM_COLS + 1);
  localparam int DW = 1 + AW + 2 * RGB_W;
  localparam logic [CW-1:0] FULL_ROW = CW'(NUM_COLS);

  logic [1:0]    ctrl_rise;
  logic [1:0]    ctrl_level_unused;
  logic [DW-1:0] data_sync;
  logic [DW-1:0] data_rise_unused;

  logic          shift_rise;
  logic          latch_rise;
  logic          oe_on;
  logic [AW-1:0] addr_s;
  rgb_t          rgb0_s;
  rgb_t          rgb1_s;

  logic [RW-1:0]       top_sr, bot_sr;
  logic [RW-1:0]       top_nx, bot_nx;
  logic [CW-1:0]       pix_cnt, pix_nx;
  logic [OE_CNT_W-1:0] oe_cnt, oe_nx;

  buf_state_e state_q, state_nx;
  logic       load_row;
  logic       drop_row;

  hub75_edge_sync #(.WIDTH(2)) u_ctrl_sync (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .data_in   ({hub75_clk_in, hub75_latch_in}),
    .level_out (ctrl_level_unused),
    .rise_out  (ctrl_rise)
  );

  // OE is inverted before synchronizing so the cleared synchronizer reads
  // as "panel dark" and does not count cycles straight out of reset.
  hub75_edge_sync #(.WIDTH(DW)) u_data_sync (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .data_in   ({~hub75_oe_in, hub75_addr_in, hub75_rgb0_in, hub75_rgb1_in}),
    .level_out (data_sync),
    .rise_out  (data_rise_unused)
  );

  assign shift_rise = ctrl_rise[1];
  assign latch_rise = ctrl_rise[0];
  assign oe_on      = data_sync[DW-1];
  assign addr_s     = data_sync[2*RGB_W +: AW];
  assign rgb0_s     = data_sync[RGB_W +: RGB_W];
  assign rgb1_s     = data_sync[0 +: RGB_W];

  // Next-value view of the shift path; a latch in the same cycle as a shift
  // commits these, so the new pixel is part of the row and of its count.
  always_comb begin
    top_nx = top_sr;
    bot_nx = bot_sr;
    pix_nx = pix_cnt;
    oe_nx  = oe_cnt;
    if (shift_rise) begin
      top_nx = {top_sr[RW-RGB_W-1:0], rgb0_s};
      bot_nx = {bot_sr[RW-RGB_W-1:0], rgb1_s};
      if (pix_cnt != '1) pix_nx = pix_cnt + 1'b1;
    end
    if (oe_on && (oe_cnt != '1)) oe_nx = oe_cnt + 1'b1;
  end

  always_comb begin
    state_nx = state_q;
    load_row = 1'b0;
    drop_row = 1'b0;
    case (state_q)
      EMPTY: begin
        if (latch_rise) begin
          load_row = 1'b1;
          state_nx = FULL;
        end
      end
      FULL: begin
        if (latch_rise && row_if.row_ready_in) begin
          load_row = 1'b1;
        end else if (latch_rise) begin
          drop_row = 1'b1;
        end else if (row_if.row_ready_in) begin
          state_nx = EMPTY;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= EMPTY;
    else         state_q <= state_nx;
  end

  assign row_if.row_valid_out = (state_q == FULL);

  // Counters restart on every latch edge, including dropped rows; the shift
  // registers are never cleared.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      top_sr  <= '0;
      bot_sr  <= '0;
      pix_cnt <= '0;
      oe_cnt  <= '0;
    end else begin
      top_sr  <= top_nx;
      bot_sr  <= bot_nx;
      pix_cnt <= latch_rise ? '0 : pix_nx;
      oe_cnt  <= latch_rise ? '0 : oe_nx;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      row_if.row_addr_out    <= '0;
      row_if.row_top_out     <= '0;
      row_if.row_bot_out     <= '0;
      row_if.pixel_count_out <= '0;
      row_if.oe_cycles_out   <= '0;
      len_err_out            <= 1'b0;
      overrun_out            <= 1'b0;
    end else begin
      len_err_out <= load_row && (pix_nx != FULL_ROW);
      if (drop_row) overrun_out <= 1'b1;
      if (load_row) begin
        row_if.row_addr_out    <= addr_s;
        row_if.row_top_out     <= top_nx;
        row_if.row_bot_out     <= bot_nx;
        row_if.pixel_count_out <= pix_nx;
        row_if.oe_cycles_out   <= oe_nx;
      end
    end
  end

endmodule

// File: tb/tb_hub75_capture.sv
module tb_hub75_capture;
  import hub75_pkg::*;

  logic       clk_in;
  logic       rst_in;
  logic       hub75_clk_in;
  logic       hub75_latch_in;
  logic       hub75_oe_in;
  logic [4:0] hub75_addr_in;
  logic [2:0] hub75_rgb0_in;
  logic [2:0] hub75_rgb1_in;
  logic       row_ready;
  logic       len_err, overrun;
  logic       len_err_s, overrun_s;

  hub75_capture_if #(.NUM_COLS(64), .SCAN_RATE(32), .OE_CNT_W(16)) row_if ();
  hub75_capture_if #(.NUM_COLS(64), .SCAN_RATE(32), .OE_CNT_W(4))  row_if_s ();

  assign row_if.row_ready_in   = row_ready;
  assign row_if_s.row_ready_in = row_ready;

  hub75_capture #(.NUM_COLS(64), .SCAN_RATE(32), .OE_CNT_W(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hub75_clk_in(hub75_clk_in), .hub75_latch_in(hub75_latch_in),
    .hub75_oe_in(hub75_oe_in), .hub75_addr_in(hub75_addr_in),
    .hub75_rgb0_in(hub75_rgb0_in), .hub75_rgb1_in(hub75_rgb1_in),
    .row_if(row_if), .len_err_out(len_err), .overrun_out(overrun)
  );

  hub75_capture #(.NUM_COLS(64), .SCAN_RATE(32), .OE_CNT_W(4)) dut_s (
    .clk_in(clk_in), .rst_in(rst_in),
    .hub75_clk_in(hub75_clk_in), .hub75_latch_in(hub75_latch_in),
    .hub75_oe_in(hub75_oe_in), .hub75_addr_in(hub75_addr_in),
    .hub75_rgb0_in(hub75_rgb0_in), .hub75_rgb1_in(hub75_rgb1_in),
    .row_if(row_if_s), .len_err_out(len_err_s), .overrun_out(overrun_s)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: pixel history (most recent last), per-row counters and
  // the row the consumer should currently see.
  logic [5:0]       hist[$];
  int               row_pix, row_oe;
  logic             exp_valid, exp_overrun;
  logic [4:0]       exp_addr;
  logic [ROW_W-1:0] exp_top, exp_bot;
  int               exp_cnt, exp_oe, exp_oe_s;

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Newest pixel sits at index 0, so the first of the last 64 lands at 63.
  function automatic logic [ROW_W-1:0] hist_row(input bit top);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (hist.size() > i) begin
        if (top) r[3*i +: 3] = hist[hist.size()-1-i][5:3];
        else     r[3*i +: 3] = hist[hist.size()-1-i][2:0];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    row_pix = 0; row_oe = 0;
    exp_valid = 0; exp_overrun = 0; exp_addr = '0;
    exp_top = '0; exp_bot = '0; exp_cnt = 0; exp_oe = 0; exp_oe_s = 0;
  endtask

  task automatic send_pixel(input logic [2:0] t, input logic [2:0] b);
    hub75_rgb0_in = t;
    hub75_rgb1_in = b;
    step(2);
    hub75_clk_in = 1'b1;
    step(2);
    hub75_clk_in = 1'b0;
    step(2);
    hist.push_back({t, b});
    if (hist.size() > 64) void'(hist.pop_front());
    row_pix = (row_pix < 127) ? row_pix + 1 : 127;
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_pixel(3'($urandom), 3'($urandom));
  endtask

  task automatic oe_low(input int n);
    hub75_oe_in = 1'b0;
    repeat (n) @(posedge clk_in);
    #1;
    hub75_oe_in = 1'b1;
    row_oe += n;
    step(3);
  endtask

  task automatic check_row(input string tag);
    chk({tag, "_valid"}, ROW_W'(row_if.row_valid_out), ROW_W'(exp_valid));
    chk({tag, "_addr"},  ROW_W'(row_if.row_addr_out), ROW_W'(exp_addr));
    chk({tag, "_top"},   row_if.row_top_out, exp_top);
    chk({tag, "_bot"},   row_if.row_bot_out, exp_bot);
    chk({tag, "_count"}, ROW_W'(row_if.pixel_count_out), ROW_W'(exp_cnt));
    chk({tag, "_oe"},    ROW_W'(row_if.oe_cycles_out), ROW_W'(exp_oe));
    chk({tag, "_oe4"},   ROW_W'(row_if_s.oe_cycles_out), ROW_W'(exp_oe_s));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"},   ROW_W'(row_if.row_valid_out), '0);
    chk({tag, "_addr"},    ROW_W'(row_if.row_addr_out), '0);
    chk({tag, "_top"},     row_if.row_top_out, '0);
    chk({tag, "_bot"},     row_if.row_bot_out, '0);
    chk({tag, "_count"},   ROW_W'(row_if.pixel_count_out), '0);
    chk({tag, "_oe"},      ROW_W'(row_if.oe_cycles_out), '0);
    chk({tag, "_len_err"}, ROW_W'(len_err), '0);
    chk({tag, "_overrun"}, ROW_W'(overrun), '0);
    chk({tag, "_valid4"},  ROW_W'(row_if_s.row_valid_out), '0);
  endtask

  // Raises latch; rdy drives ready only during the cycle the latch edge is
  // committed (third clk_in edge with latch high).
  task automatic do_latch(input string tag, input bit rdy);
    logic was_valid, load, exp_len;
    was_valid = exp_valid;
    hub75_latch_in = 1'b1;
    step(2);
    chk({tag, "_pre_valid"}, ROW_W'(row_if.row_valid_out), ROW_W'(was_valid));
    if (rdy) row_ready = 1'b1;
    step(1);
    row_ready = 1'b0;
    load = !was_valid || rdy;
    if (load) begin
      exp_valid = 1'b1;
      exp_addr  = hub75_addr_in;
      exp_top   = hist_row(1'b1);
      exp_bot   = hist_row(1'b0);
      exp_cnt   = row_pix;
      exp_oe    = (row_oe > 65535) ? 65535 : row_oe;
      exp_oe_s  = (row_oe > 15) ? 15 : row_oe;
      exp_len   = (row_pix != 64);
    end else begin
      exp_overrun = 1'b1;
      exp_len     = 1'b0;
    end
    row_pix = 0;
    row_oe  = 0;
    check_row(tag);
    chk({tag, "_len_err"},  ROW_W'(len_err), ROW_W'(exp_len));
    chk({tag, "_len_err4"}, ROW_W'(len_err_s), ROW_W'(exp_len));
    chk({tag, "_overrun"},  ROW_W'(overrun), ROW_W'(exp_overrun));
    chk({tag, "_overrun4"}, ROW_W'(overrun_s), ROW_W'(exp_overrun));
    step(1);
    chk({tag, "_len_err_end"}, ROW_W'(len_err), '0);
    hub75_latch_in = 1'b0;
    step(3);
  endtask

  task automatic consume(input string tag);
    row_ready = 1'b1;
    step(1);
    row_ready = 1'b0;
    exp_valid = 1'b0;
    chk({tag, "_drained"}, ROW_W'(row_if.row_valid_out), '0);
  endtask

  initial begin
    int n;
    logic [ROW_W-1:0] t;
    rst_in = 1'b0;
    hub75_clk_in = 1'b0; hub75_latch_in = 1'b0; hub75_oe_in = 1'b1;
    hub75_addr_in = '0; hub75_rgb0_in = '0; hub75_rgb1_in = '0;
    row_ready = 1'b0;
    model_reset();
    step(3);
    check_reset("reset");
    rst_in = 1'b1;
    step(3);

    // Nominal row
    hub75_addr_in = 5'd5;
    for (int k = 0; k < 64; k++) send_pixel({k[0], 1'b0, 1'b1}, 3'b010);
    do_latch("nominal", 1'b0);
    t = row_if.row_top_out;
    chk("nominal_pix0_at_63", ROW_W'(t[191:189]), ROW_W'(3'b001));
    chk("nominal_pix1_at_62", ROW_W'(t[188:186]), ROW_W'(3'b101));
    consume("nominal");

    // Short row
    hub75_addr_in = 5'($urandom);
    send_random(60);
    do_latch("short", 1'b0);
    consume("short");

    // OE on-time, with saturation in the narrow-counter instance
    hub75_addr_in = 5'($urandom);
    send_random(64);
    oe_low(200);
    do_latch("oe200", 1'b0);
    consume("oe200");

    // Random rows: lengths around NUM_COLS, random OE time
    for (int r = 0; r < 3; r++) begin
      hub75_addr_in = 5'($urandom);
      n = $urandom_range(58, 70);
      send_random(n);
      oe_low($urandom_range(1, 40));
      do_latch("rand", 1'b0);
      consume("rand");
    end

    // Transfer and latch in the same cycle
    hub75_addr_in = 5'd7;
    send_random(64);
    do_latch("same_a", 1'b0);
    hub75_addr_in = 5'd9;
    send_random(64);
    do_latch("same_b", 1'b1);
    consume("same_b");

    // Backpressure: second row dropped, first row held
    hub75_addr_in = 5'd3;
    send_random(64);
    do_latch("bp_a", 1'b0);
    hub75_addr_in = 5'd12;
    send_random(64);
    do_latch("bp_b", 1'b0);
    step(20);
    check_row("bp_hold");
    chk("bp_sticky", ROW_W'(overrun), '1 >> (ROW_W - 1));
    consume("bp");
    step(2);
    chk("bp_idle_valid", ROW_W'(row_if.row_valid_out), '0);
    chk("bp_sticky_after", ROW_W'(overrun), ROW_W'(exp_overrun));

    // Reset in the middle of a row
    hub75_addr_in = 5'($urandom);
    send_random(30);
    rst_in = 1'b0;
    #2;
    check_reset("midreset_async");
    step(2);
    check_reset("midreset_held");
    model_reset();
    rst_in = 1'b1;
    step(3);
    hub75_addr_in = 5'($urandom);
    send_random(64);
    do_latch("after_reset", 1'b0);
    consume("after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hub75_capture.md
Name: hub75_capture

Overview:
- Receive-side counterpart of the HUB75 panel driver. It oversamples the six HUB75 output pins (clk, latch, OE, addr, rgb0, rgb1) on the system clock and rebuilds each shifted row into a parallel buffer.
- It then presents each row on a valid/ready stream.
- Used as an on-FPGA loopback monitor and panel emulator, so the driver and frame_manager can be checked in hardware and simulation without a physical panel.

Parameters:
- NUM_COLS, 64, pixels shifted per row per half-panel
- SCAN_RATE, 32, number of row addresses (addr width = $clog2(SCAN_RATE))
- OE_CNT_W, 16, width of the OE-on-time counter

Ports:
- clk_in  input  1  system clock; must be >= 4x HUB75 clock frequency
- rst_in  input  1  asynchronous, active-low reset
- hub75_clk_in  input  1  panel shift clock from the driver
- hub75_latch_in  input  1  panel latch; rising edge commits a row
- hub75_oe_in  input  1  output enable, active low
- hub75_addr_in  input  $clog2(SCAN_RATE)  row address
- hub75_rgb0_in  input  3  top-half pixel bits {r,g,b}
- hub75_rgb1_in  input  3  bottom-half pixel bits {r,g,b}
- row_valid_out  output  1  captured row available
- row_ready_in  input  1  consumer accepts row
- row_addr_out  output  $clog2(SCAN_RATE)  address sampled at latch
- row_top_out  output  NUM_COLS*3  top-half row; pixel i at bits [3i+2:3i]
- row_bot_out  output  NUM_COLS*3  bottom-half row, same packing
- pixel_count_out  output  $clog2(NUM_COLS+1)  clocks seen before this latch
- oe_cycles_out  output  OE_CNT_W  clk_in cycles OE was low since the previous latch
- len_err_out  output  1  one-cycle pulse: latched row had pixel count != NUM_COLS
- overrun_out  output  1  sticky: a row was dropped because the buffer was full

Behaviour:
- **Reset**: rst_in low clears all registers asynchronously. All outputs are 0 and synchronizers are cleared.
- **Synchronizers**: every HUB75 input passes through a 2-FF synchronizer plus a previous-value register. Data and control use identical depth, so data stays aligned with clk edges.
- **Input timing**: inputs must hold each level for >= 2 clk_in cycles. Data must be stable from 1 cycle before to 1 cycle after each hub75_clk rise.
- **Shift on clock edge**: a synced hub75_clk rising edge (s2 & ~s3) shifts the shift registers toward higher index.
  - The new rgb0/rgb1 bits enter index 0, so the first pixel shifted ends at index NUM_COLS-1, matching panel chain order.
  - The pixel counter increments, saturating at NUM_COLS+… max code (2^W-1).
- **OE counter**: increments every cycle the synced OE is low, saturating at all-ones.
- **Latch rising edge, output buffer free** (row_valid_out=0, or row_valid_out & row_ready_in in the same cycle):
  - Load row_top/bot, row_addr (synced addr), pixel_count and oe_cycles.
  - Set row_valid_out.
  - Pulse len_err_out if pixel count != NUM_COLS.
  - Clear the pixel and OE counters.
  - Shift-register contents are not cleared.
- **Latch rising edge, buffer full and not consumed**: the row is dropped, overrun_out is set (sticky until reset), and the counters are still cleared.
- **Latency**: row_valid_out rises on the 3rd clk_in rising edge at which hub75_latch_in is sampled high.
- **Shift and latch in the same cycle**: the shift takes effect first, and the latched row includes the new pixel. The count includes it too.
- **Handshake**:
  - row_valid_out stays high, and the row outputs stay stable, until row_valid_out & row_ready_in.
  - On that transfer row_valid_out drops next cycle, unless a new latch loads in the same cycle, in which case it stays high with the new data.
- **Stale shifts**: clock edges while row_valid_out is high shift normally. Only the output buffer is held.
- **FSM**: two states on the output buffer, EMPTY and FULL.
  - EMPTY -> FULL on a latch edge.
  - FULL -> EMPTY on a transfer with no latch.
  - FULL -> FULL on a transfer with a latch (reload), or when holding.

Decomposition:
- **Package hub75_pkg**:
  - rgb_t packed struct {r,g,b}
  - localparams for row width (NUM_COLS*3) and address width
  - buffer state enum {EMPTY, FULL}
- **Sub-module hub75_edge_sync**: 2-FF synchronizer, delayed copy, and rise-pulse output, parameterized by width. Used for the control pins and the data bus.

Test Plan:
1. **Nominal row**: 64 hub75_clk pulses, pixel k top={k[0],0,1}, bottom=3'b010, addr=5, then latch. Required response:
   - row_valid_out after 3 clk_in
   - row_addr_out=5, pixel_count_out=64, len_err_out=0
   - row_top_out index 63 holds pixel 0
2. **Short row**: 60 pulses then latch -> pixel_count_out=60, len_err_out pulses once, valid asserted.
3. **OE timing**: hold OE low for 200 clk_in cycles between latches -> oe_cycles_out=200 on the next row. With OE_CNT_W=4 and 200 cycles -> 15.
4. **Backpressure**: row_ready_in=0, two latches in sequence -> first row retained, overrun_out=1 and stays 1. Raise ready -> one transfer, then valid=0.
5. **Same-cycle transfer and latch**: ready high in the exact cycle the second latch edge registers -> valid stays 1, new address appears, overrun_out=0.
6. **Reset mid-row**: assert rst_in low after 30 pulses, release, send 64 pulses + latch -> pixel_count_out=64, all outputs were 0 during reset.
